// File: rtl/commit_pkg.sv
// Shared types for the buffered commit stage: head classification, CSR bus FSM
// states and the width-independent part of a queued entry.
package commit_pkg;

  localparam int unsigned EXC_ILLEGAL_INST = 2;

  typedef enum logic [2:0] {
    KindInterrupt,
    KindEmpty,
    KindException,
    KindMret,
    KindWaitFifo,
    KindCsr,
    KindCommit
  } commit_kind_e;

  typedef enum logic [1:0] {
    CsrIdle,
    CsrWrite,
    CsrBresp,
    CsrDone
  } csr_state_e;

  typedef struct packed {
    logic       jump_valid;
    logic       exc_valid;
    logic       mret;
    logic       st_valid;
    logic       csr_valid;
    logic [5:0] exc_num;
    logic [1:0] st_size;
    logic [11:0] csr_addr;
  } commit_entry_t;

endpackage

// File: rtl/commit_entry_fifo.sv
// In-order circular queue of commit entries with extra-MSB pointers, flush clear
// and a per-slot valid mask so the owner can scan occupied entries.
module commit_entry_fifo #(
  parameter int unsigned Depth = 4,
  parameter type entry_t = logic
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  entry_t           push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output entry_t           head_o,
  output entry_t           entries_o [Depth],
  output logic [Depth-1:0] valid_o
);

  localparam int unsigned AW = $clog2(Depth);

  logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   count;
  logic [AW-1:0] off;
  entry_t        mem_q [Depth];
  entry_t        mem_d [Depth];

  assign count   = wr_q - rd_q;
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign head_o  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    mem_d = mem_q;
    if (flush_i) begin
      // Flush wins over both ports: anything enqueued this cycle is dropped.
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push_i && !full_o) begin
        mem_d[wr_q[AW-1:0]] = push_data_i;
        wr_d = wr_q + 1'b1;
      end
      if (pop_i && !empty_o) begin
        rd_d = rd_q + 1'b1;
      end
    end
  end

  always_comb begin
    off = '0;
    for (int i = 0; i < Depth; i++) begin
      off          = AW'(i) - rd_q[AW-1:0];
      valid_o[i]   = ({1'b0, off} < count);
      entries_o[i] = mem_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/commit_buffered.sv
// Buffered commit stage: queues executed instructions and retires the head as a
// writeback, store, CSR bus write, exception, mret or interrupt.
module commit_buffered
  import commit_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned CSR_TIMEOUT = 16,
  parameter int unsigned NUM_REGS    = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ex_valid,
  output logic                        ex_ready,
  input  logic [$clog2(NUM_REGS)-1:0] ex_rd,
  input  logic [XLEN-1:0]             ex_rd_val,
  input  logic [XLEN-1:0]             ex_pc,
  input  logic [XLEN-1:0]             ex_jump_pc,
  input  logic                        ex_jump_valid,
  input  logic [5:0]                  ex_exc_num,
  input  logic [XLEN-1:0]             ex_exc_val,
  input  logic                        ex_exc_valid,
  input  logic                        ex_mret,
  input  logic [XLEN-1:0]             ex_st_addr,
  input  logic [XLEN-1:0]             ex_st_val,
  input  logic [1:0]                  ex_st_size,
  input  logic                        ex_st_valid,
  input  logic [11:0]                 ex_csr_addr,
  input  logic [XLEN-1:0]             ex_csr_val,
  input  logic                        ex_csr_valid,
  input  logic                        irq_valid,
  input  logic [XLEN-2:0]             irq_num,
  input  logic                        dfifo_full,
  output logic [XLEN-1:0]             dfifo_addr,
  output logic [XLEN-1:0]             dfifo_val,
  output logic [1:0]                  dfifo_size,
  output logic                        dfifo_valid,
  output logic [$clog2(NUM_REGS)-1:0] rd_out,
  output logic [XLEN-1:0]             rd_val_out,
  output logic                        rd_valid_out,
  output logic [NUM_REGS-1:0]         pending_rd,
  output logic                        commit_valid,
  output logic                        flush,
  output logic [XLEN-1:0]             flush_pc,
  output logic [11:0]                 csr_waddr,
  output logic [XLEN-1:0]             csr_wdata,
  output logic                        csr_wvalid,
  input  logic                        csr_wready,
  input  logic [2:0]                  csr_bresp,
  input  logic                        csr_bvalid,
  output logic                        csr_bready,
  input  logic [XLEN-3:0]             mtvec_base,
  input  logic [XLEN-1:0]             mepc_in,
  output logic                        exc_valid,
  output logic [XLEN-1:0]             exc_mepc,
  output logic [XLEN-1:0]             exc_mcause,
  output logic [XLEN-1:0]             exc_mtval,
  output logic                        irq_taken
);

  localparam int unsigned RegW   = $clog2(NUM_REGS);
  localparam int unsigned TimerW = $clog2(CSR_TIMEOUT + 1);

  typedef struct packed {
    commit_entry_t   hdr;
    logic [RegW-1:0] rd;
    logic [XLEN-1:0] rd_val;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] jump_pc;
    logic [XLEN-1:0] exc_val;
    logic [XLEN-1:0] st_addr;
    logic [XLEN-1:0] st_val;
    logic [XLEN-1:0] csr_val;
  } entry_t;

  entry_t             entry_in;
  entry_t             head;
  entry_t             q_entries [DEPTH];
  logic [DEPTH-1:0]   q_valid;
  logic               q_full, q_empty;
  logic               push, pop, do_commit;
  logic [XLEN-1:0]    mtvec;
  commit_kind_e       kind;

  csr_state_e         csr_q, csr_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic               err_q, err_d;
  logic               irq_pend_q, irq_pend_d;
  logic [XLEN-1:0]    resume_pc_q, resume_pc_d;

  assign mtvec    = {mtvec_base, 2'b00};
  assign ex_ready = !q_full && !reset;
  assign push     = ex_valid && ex_ready;

  always_comb begin
    entry_in                = '0;
    entry_in.hdr.jump_valid = ex_jump_valid;
    entry_in.hdr.exc_valid  = ex_exc_valid;
    entry_in.hdr.mret       = ex_mret;
    entry_in.hdr.st_valid   = ex_st_valid;
    entry_in.hdr.csr_valid  = ex_csr_valid;
    entry_in.hdr.exc_num    = ex_exc_num;
    entry_in.hdr.st_size    = ex_st_size;
    entry_in.hdr.csr_addr   = ex_csr_addr;
    entry_in.rd             = ex_rd;
    entry_in.rd_val         = ex_rd_val;
    entry_in.pc             = ex_pc;
    entry_in.jump_pc        = ex_jump_pc;
    entry_in.exc_val        = ex_exc_val;
    entry_in.st_addr        = ex_st_addr;
    entry_in.st_val         = ex_st_val;
    entry_in.csr_val        = ex_csr_val;
  end

  commit_entry_fifo #(
    .Depth   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (flush),
    .push_i      (push),
    .push_data_i (entry_in),
    .pop_i       (pop),
    .full_o      (q_full),
    .empty_o     (q_empty),
    .head_o      (head),
    .entries_o   (q_entries),
    .valid_o     (q_valid)
  );

  // Once a CSR transaction is under way a store-full stall must not reclassify the head.
  always_comb begin
    kind = KindCommit;
    if (reset) begin
      kind = KindEmpty;
    end else if (irq_pend_q) begin
      kind = KindInterrupt;
    end else if (q_empty) begin
      kind = KindEmpty;
    end else if (head.hdr.exc_valid) begin
      kind = KindException;
    end else if (head.hdr.mret) begin
      kind = KindMret;
    end else if (head.hdr.st_valid && dfifo_full && (csr_q == CsrIdle)) begin
      kind = KindWaitFifo;
    end else if (head.hdr.csr_valid) begin
      kind = KindCsr;
    end
  end

  always_comb begin
    pending_rd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_valid[i]) pending_rd[q_entries[i].rd] = 1'b1;
    end
    pending_rd[0] = 1'b0;
    if (reset) pending_rd = '0;
  end

  always_comb begin
    csr_d        = csr_q;
    timer_d      = timer_q;
    err_d        = err_q;
    csr_wvalid   = 1'b0;
    csr_waddr    = '0;
    csr_wdata    = '0;
    csr_bready   = 1'b0;
    unique case (csr_q)
      CsrIdle: begin
        if (kind == KindCsr) begin
          csr_d   = CsrWrite;
          timer_d = '0;
          err_d   = 1'b0;
        end
      end
      CsrWrite: begin
        csr_wvalid = !reset;
        csr_waddr  = reset ? '0 : head.hdr.csr_addr;
        csr_wdata  = reset ? '0 : head.csr_val;
        if (timer_q == TimerW'(CSR_TIMEOUT)) begin
          csr_d = CsrDone;
          err_d = 1'b1;
        end else begin
          timer_d = timer_q + TimerW'(1);
          if (csr_wready) csr_d = CsrBresp;
        end
      end
      CsrBresp: begin
        csr_bready = !reset;
        if (csr_bvalid) begin
          csr_d = CsrDone;
          err_d = err_q | (csr_bresp != 3'd0);
        end else if (timer_q == TimerW'(CSR_TIMEOUT)) begin
          csr_d = CsrDone;
          err_d = 1'b1;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      CsrDone: begin
        csr_d   = CsrIdle;
        timer_d = '0;
      end
      default: csr_d = CsrIdle;
    endcase
  end

  always_comb begin
    pop          = 1'b0;
    do_commit    = 1'b0;
    commit_valid = 1'b0;
    flush        = 1'b0;
    flush_pc     = '0;
    rd_valid_out = 1'b0;
    rd_out       = '0;
    rd_val_out   = '0;
    dfifo_valid  = 1'b0;
    dfifo_addr   = '0;
    dfifo_val    = '0;
    dfifo_size   = '0;
    exc_valid    = 1'b0;
    exc_mepc     = '0;
    exc_mcause   = '0;
    exc_mtval    = '0;
    irq_taken    = 1'b0;
    irq_pend_d   = irq_pend_q;
    resume_pc_d  = resume_pc_q;

    unique case (kind)
      KindInterrupt: begin
        irq_taken  = 1'b1;
        exc_valid  = 1'b1;
        exc_mcause = {1'b1, irq_num};
        exc_mepc   = resume_pc_q;
        flush      = 1'b1;
        flush_pc   = mtvec;
        irq_pend_d = 1'b0;
      end
      KindException: begin
        exc_valid  = 1'b1;
        exc_mcause = {{(XLEN-6){1'b0}}, head.hdr.exc_num};
        exc_mtval  = head.exc_val;
        exc_mepc   = head.pc;
        flush      = 1'b1;
        flush_pc   = mtvec;
        pop        = 1'b1;
      end
      KindMret: begin
        flush    = 1'b1;
        flush_pc = mepc_in;
        pop      = 1'b1;
      end
      KindCsr: begin
        if (csr_q == CsrDone) begin
          if (err_q) begin
            exc_valid  = 1'b1;
            exc_mcause = XLEN'(EXC_ILLEGAL_INST);
            exc_mepc   = head.pc;
            flush      = 1'b1;
            flush_pc   = mtvec;
            pop        = 1'b1;
          end else begin
            do_commit = 1'b1;
          end
        end
      end
      KindCommit: do_commit = 1'b1;
      default: ;
    endcase

    if (do_commit) begin
      pop          = 1'b1;
      commit_valid = 1'b1;
      rd_valid_out = (head.rd != '0);
      rd_out       = rd_valid_out ? head.rd : '0;
      rd_val_out   = rd_valid_out ? head.rd_val : '0;
      dfifo_valid  = head.hdr.st_valid;
      dfifo_addr   = dfifo_valid ? head.st_addr : '0;
      dfifo_val    = dfifo_valid ? head.st_val : '0;
      dfifo_size   = dfifo_valid ? head.hdr.st_size : '0;
      flush        = head.hdr.jump_valid;
      flush_pc     = flush ? head.jump_pc : '0;
      resume_pc_d  = flush ? head.jump_pc : head.pc + XLEN'(4);
    end

    // The retiring instruction goes first; the interrupt is taken on the next cycle.
    if (irq_valid && (kind == KindEmpty || commit_valid)) irq_pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      csr_q       <= CsrIdle;
      timer_q     <= '0;
      err_q       <= 1'b0;
      irq_pend_q  <= 1'b0;
      resume_pc_q <= '0;
    end else begin
      csr_q       <= csr_d;
      timer_q     <= timer_d;
      err_q       <= err_d;
      irq_pend_q  <= irq_pend_d;
      resume_pc_q <= resume_pc_d;
    end
  end

endmodule

// File: tb/tb_commit_buffered.sv
// Directed bench for commit_buffered: store backpressure, branch flush, CSR bus
// success/error/timeout, interrupt after retire and reset mid-transaction.
module tb_commit_buffered;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_ready;
  logic [4:0]  ex_rd;
  logic [31:0] ex_rd_val, ex_pc, ex_jump_pc;
  logic        ex_jump_valid;
  logic [5:0]  ex_exc_num;
  logic [31:0] ex_exc_val;
  logic        ex_exc_valid, ex_mret;
  logic [31:0] ex_st_addr, ex_st_val;
  logic [1:0]  ex_st_size;
  logic        ex_st_valid;
  logic [11:0] ex_csr_addr;
  logic [31:0] ex_csr_val;
  logic        ex_csr_valid;
  logic        irq_valid;
  logic [30:0] irq_num;
  logic        dfifo_full;
  logic [31:0] dfifo_addr, dfifo_val;
  logic [1:0]  dfifo_size;
  logic        dfifo_valid;
  logic [4:0]  rd_out;
  logic [31:0] rd_val_out;
  logic        rd_valid_out;
  logic [31:0] pending_rd;
  logic        commit_valid, flush;
  logic [31:0] flush_pc;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        csr_wvalid, csr_wready;
  logic [2:0]  csr_bresp;
  logic        csr_bvalid, csr_bready;
  logic [29:0] mtvec_base;
  logic [31:0] mepc_in;
  logic        exc_valid;
  logic [31:0] exc_mepc, exc_mcause, exc_mtval;
  logic        irq_taken;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  commit_buffered #(
    .XLEN        (32),
    .DEPTH       (4),
    .CSR_TIMEOUT (16),
    .NUM_REGS    (32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_rd         (ex_rd),
    .ex_rd_val     (ex_rd_val),
    .ex_pc         (ex_pc),
    .ex_jump_pc    (ex_jump_pc),
    .ex_jump_valid (ex_jump_valid),
    .ex_exc_num    (ex_exc_num),
    .ex_exc_val    (ex_exc_val),
    .ex_exc_valid  (ex_exc_valid),
    .ex_mret       (ex_mret),
    .ex_st_addr    (ex_st_addr),
    .ex_st_val     (ex_st_val),
    .ex_st_size    (ex_st_size),
    .ex_st_valid   (ex_st_valid),
    .ex_csr_addr   (ex_csr_addr),
    .ex_csr_val    (ex_csr_val),
    .ex_csr_valid  (ex_csr_valid),
    .irq_valid     (irq_valid),
    .irq_num       (irq_num),
    .dfifo_full    (dfifo_full),
    .dfifo_addr    (dfifo_addr),
    .dfifo_val     (dfifo_val),
    .dfifo_size    (dfifo_size),
    .dfifo_valid   (dfifo_valid),
    .rd_out        (rd_out),
    .rd_val_out    (rd_val_out),
    .rd_valid_out  (rd_valid_out),
    .pending_rd    (pending_rd),
    .commit_valid  (commit_valid),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .csr_waddr     (csr_waddr),
    .csr_wdata     (csr_wdata),
    .csr_wvalid    (csr_wvalid),
    .csr_wready    (csr_wready),
    .csr_bresp     (csr_bresp),
    .csr_bvalid    (csr_bvalid),
    .csr_bready    (csr_bready),
    .mtvec_base    (mtvec_base),
    .mepc_in       (mepc_in),
    .exc_valid     (exc_valid),
    .exc_mepc      (exc_mepc),
    .exc_mcause    (exc_mcause),
    .exc_mtval     (exc_mtval),
    .irq_taken     (irq_taken)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic ex_idle();
    ex_valid      = 1'b0;
    ex_rd         = '0;
    ex_rd_val     = '0;
    ex_pc         = '0;
    ex_jump_pc    = '0;
    ex_jump_valid = 1'b0;
    ex_exc_num    = '0;
    ex_exc_val    = '0;
    ex_exc_valid  = 1'b0;
    ex_mret       = 1'b0;
    ex_st_addr    = '0;
    ex_st_val     = '0;
    ex_st_size    = '0;
    ex_st_valid   = 1'b0;
    ex_csr_addr   = '0;
    ex_csr_val    = '0;
    ex_csr_valid  = 1'b0;
  endtask

  task automatic ex_alu(input logic [4:0] rd, input logic [31:0] val, input logic [31:0] pc);
    ex_idle();
    ex_valid  = 1'b1;
    ex_rd     = rd;
    ex_rd_val = val;
    ex_pc     = pc;
  endtask

  task automatic ex_csr(input logic [4:0] rd, input logic [31:0] val, input logic [31:0] pc);
    ex_alu(rd, val, pc);
    ex_csr_valid = 1'b1;
    ex_csr_addr  = 12'h305;
    ex_csr_val   = 32'hDEAD;
  endtask

  initial begin
    reset      = 1'b1;
    ex_idle();
    irq_valid  = 1'b0;
    irq_num    = '0;
    dfifo_full = 1'b0;
    csr_wready = 1'b0;
    csr_bresp  = '0;
    csr_bvalid = 1'b0;
    mtvec_base = 30'h400;
    mepc_in    = 32'h300;

    cyc();
    cyc();
    sample();
    check_eq("rst_ready", ex_ready, 0);
    check_eq("rst_commit", commit_valid, 0);
    check_eq("rst_pending", pending_rd, 0);
    check_eq("rst_wvalid", csr_wvalid, 0);
    cyc();
    reset = 1'b0;
    sample();
    check_eq("rst_ready_after", ex_ready, 1);
    cyc();

    // Stores back up behind a full data FIFO, then drain in order.
    dfifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ex_idle();
      ex_valid    = 1'b1;
      ex_st_valid = 1'b1;
      ex_st_addr  = 32'h10 + 4 * i;
      ex_st_val   = 32'hA0 + i;
      ex_pc       = 32'h20 + 4 * i;
      sample();
      check_eq("t1_ready", ex_ready, (i < 4) ? 1 : 0);
      check_eq("t1_hold", dfifo_valid, 0);
      cyc();
    end
    ex_idle();
    dfifo_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample();
      check_eq("t1_st_valid", dfifo_valid, 1);
      check_eq("t1_st_addr", dfifo_addr, 32'h10 + 4 * i);
      check_eq("t1_st_val", dfifo_val, 32'hA0 + i);
      check_eq("t1_ready_back", ex_ready, (i > 0) ? 1 : 0);
      cyc();
    end
    sample();
    check_eq("t1_drained", dfifo_valid, 0);
    cyc();

    // ALU, taken branch, ALU: the third entry is flushed away.
    ex_alu(5'd5, 32'h1234, 32'hF8);
    cyc();
    ex_alu(5'd0, 32'h0, 32'h100);
    ex_jump_valid = 1'b1;
    ex_jump_pc    = 32'h200;
    sample();
    check_eq("t2_pending5", pending_rd, 32'h20);
    check_eq("t2_rd_valid", rd_valid_out, 1);
    check_eq("t2_rd", rd_out, 5);
    check_eq("t2_rd_val", rd_val_out, 32'h1234);
    cyc();
    ex_alu(5'd7, 32'h5555, 32'h104);
    sample();
    check_eq("t2_flush", flush, 1);
    check_eq("t2_flush_pc", flush_pc, 32'h200);
    check_eq("t2_br_commit", commit_valid, 1);
    check_eq("t2_pending_clr", pending_rd, 0);
    cyc();
    ex_idle();
    sample();
    check_eq("t2_discard", commit_valid, 0);
    check_eq("t2_discard_pend", pending_rd, 0);
    cyc();

    // CSR write: clean response, then error response.
    for (int k = 0; k < 2; k++) begin
      ex_csr(5'd3, 32'h77, 32'h200 + 4 * k);
      cyc();
      ex_idle();
      sample();
      check_eq("t3_idle_wvalid", csr_wvalid, 0);
      check_eq("t3_pending3", pending_rd, 32'h8);
      cyc();
      for (int c = 0; c < 3; c++) begin
        csr_wready = (c == 2);
        sample();
        check_eq("t3_wvalid", csr_wvalid, 1);
        check_eq("t3_waddr", csr_waddr, 12'h305);
        check_eq("t3_wdata", csr_wdata, 32'hDEAD);
        cyc();
      end
      csr_wready = 1'b0;
      csr_bvalid = 1'b1;
      csr_bresp  = (k == 0) ? 3'd0 : 3'd2;
      sample();
      check_eq("t3_bready", csr_bready, 1);
      check_eq("t3_no_commit_early", commit_valid, 0);
      cyc();
      csr_bvalid = 1'b0;
      csr_bresp  = '0;
      sample();
      if (k == 0) begin
        check_eq("t3_ok_commit", commit_valid, 1);
        check_eq("t3_ok_rd", rd_out, 3);
        check_eq("t3_ok_rd_val", rd_val_out, 32'h77);
        check_eq("t3_ok_exc", exc_valid, 0);
      end else begin
        check_eq("t3_err_exc", exc_valid, 1);
        check_eq("t3_err_mcause", exc_mcause, 2);
        check_eq("t3_err_mtval", exc_mtval, 0);
        check_eq("t3_err_mepc", exc_mepc, 32'h204);
        check_eq("t3_err_flush_pc", flush_pc, 32'h1000);
        check_eq("t3_err_commit", commit_valid, 0);
      end
      cyc();
      sample();
      check_eq("t3_after", commit_valid | exc_valid, 0);
      cyc();
    end

    // CSR write that never sees wready times out.
    ex_csr(5'd2, 32'h11, 32'h300);
    cyc();
    ex_idle();
    cyc();
    for (int c = 0; c < 17; c++) begin
      sample();
      check_eq("t4_wait_exc", exc_valid, 0);
      check_eq("t4_wait_wvalid", csr_wvalid, 1);
      check_eq("t4_wait_bready", csr_bready, 0);
      cyc();
    end
    sample();
    check_eq("t4_exc", exc_valid, 1);
    check_eq("t4_mcause", exc_mcause, 2);
    check_eq("t4_mepc", exc_mepc, 32'h300);
    check_eq("t4_flush_pc", flush_pc, 32'h1000);
    check_eq("t4_bready", csr_bready, 0);
    cyc();

    // Interrupt arriving with the retire of pc 0x40.
    ex_alu(5'd1, 32'h9, 32'h40);
    cyc();
    ex_idle();
    irq_valid = 1'b1;
    irq_num   = 31'd7;
    sample();
    check_eq("t5_commit", commit_valid, 1);
    check_eq("t5_not_yet", irq_taken, 0);
    cyc();
    irq_valid = 1'b0;
    sample();
    check_eq("t5_irq_taken", irq_taken, 1);
    check_eq("t5_exc", exc_valid, 1);
    check_eq("t5_mcause", exc_mcause, 32'h80000007);
    check_eq("t5_mepc", exc_mepc, 32'h44);
    check_eq("t5_flush_pc", flush_pc, 32'h1000);
    cyc();
    sample();
    check_eq("t5_irq_once", irq_taken, 0);
    cyc();

    // Reset while waiting for the write response with three entries queued.
    ex_csr(5'd0, 32'h0, 32'h500);
    cyc();
    ex_alu(5'd4, 32'h44, 32'h504);
    cyc();
    ex_alu(5'd6, 32'h66, 32'h508);
    csr_wready = 1'b1;
    cyc();
    ex_idle();
    csr_wready = 1'b0;
    sample();
    check_eq("t6_bready", csr_bready, 1);
    check_eq("t6_pending", pending_rd, 32'h50);
    cyc();
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      sample();
      check_eq("t6_rst_ready", ex_ready, 0);
      check_eq("t6_rst_bready", csr_bready, 0);
      check_eq("t6_rst_pending", pending_rd, 0);
      check_eq("t6_rst_outs", {commit_valid, flush, exc_valid, rd_valid_out,
                               dfifo_valid, csr_wvalid, irq_taken}, 0);
      cyc();
    end
    reset      = 1'b0;
    csr_bvalid = 1'b1;
    sample();
    check_eq("t6_ready", ex_ready, 1);
    check_eq("t6_empty", pending_rd, 0);
    check_eq("t6_no_bready", csr_bready, 0);
    cyc();
    csr_bvalid = 1'b0;
    sample();
    check_eq("t6_idle_wvalid", csr_wvalid, 0);
    check_eq("t6_idle_commit", commit_valid, 0);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/commit_buffered.md
Name: commit_buffered

Overview:
Parametrised successor commit stage that sits between execute and the register file, data FIFO and CSR bus.
- Execute gets a DEPTH-entry in-order commit queue with a valid/ready handshake instead of a single latch plus stall.
- Retires the head entry: register writeback, store issue, CSR write over an AXI-lite-like bus, exception, mret or interrupt.
- New behaviour: CSR write timeout, per-register pending bitmask, flush-safe enqueue.

Parameters:
XLEN, 32, data/address width
DEPTH, 4, queue entries; power of 2, >=2
CSR_TIMEOUT, 16, cycles allowed in CSR WRITE+BRESP before fault
NUM_REGS, 32, architectural registers (rd index width log2(NUM_REGS))

Ports:
clk  in  1  clock
reset  in  1  reset
ex_valid/ex_ready  in/out  1/1  enqueue handshake
ex_rd, ex_rd_val  in  log2(NUM_REGS), XLEN  destination register and value
ex_pc, ex_jump_pc, ex_jump_valid  in  XLEN, XLEN, 1  instruction PC, branch target, taken
ex_exc_num, ex_exc_val, ex_exc_valid  in  6, XLEN, 1  synchronous exception
ex_mret  in  1  exception return
ex_st_addr, ex_st_val, ex_st_size, ex_st_valid  in  XLEN, XLEN, 2, 1  store
ex_csr_addr, ex_csr_val, ex_csr_valid  in  12, XLEN, 1  CSR write
irq_valid, irq_num  in  1, XLEN-1  interrupt request
dfifo_full  in  1; dfifo_addr/val/size/valid  out  XLEN/XLEN/2/1  store FIFO
rd_out, rd_val_out, rd_valid_out  out  log2(NUM_REGS), XLEN, 1  writeback
pending_rd  out  NUM_REGS  bitmask of rd held by queued entries
commit_valid, flush, flush_pc  out  1, 1, XLEN  pipeline control
csr_waddr, csr_wdata, csr_wvalid  out  12, XLEN, 1; csr_wready in 1
csr_bresp, csr_bvalid  in  3, 1; csr_bready  out  1
mtvec_base, mepc_in  in  XLEN-2, XLEN
exc_valid, exc_mepc, exc_mcause, exc_mtval, irq_taken  out  1, XLEN, XLEN, XLEN, 1

Behaviour:
- Reset: clk is the clock; reset is synchronous and active-high.
  - Queue empty, CSR FSM IDLE, timeout counter 0, resume_pc 0, irq_pend 0.
  - All outputs 0, including ex_ready while reset is high; ex_ready is 1 the cycle after reset deasserts.
  - Reset mid-CSR-transaction abandons it; no bready is issued.
- Queue:
  - Circular buffer with log2(DEPTH)+1-bit pointers; ex_ready = !full. Enqueue on ex_valid&ex_ready; the head is visible next cycle.
  - No bypass: when full, a dequeue this cycle does not admit an enqueue this cycle.
- Flush (any cycle flush=1): queue cleared at the edge; an enqueue in that cycle is discarded.
- Head kind, priority order: INTERRUPT (irq_pend) > EMPTY > EXCEPTION > MRET > WAIT_FIFO (st_valid&dfifo_full) > CSR (csr_valid) > COMMIT.
- COMMIT:
  - Dequeue; commit_valid=1.
  - rd_valid_out when rd!=0.
  - dfifo_valid when st_valid.
  - flush=jump_valid, flush_pc=jump_pc.
- EXCEPTION: exc_valid=1, mcause={0,num}, mtval=exc_val, mepc=pc, flush, flush_pc={mtvec_base,2'b0}, dequeue.
- MRET: flush, flush_pc=mepc_in, dequeue.
- WAIT_FIFO: hold the head; no outputs asserted.
- CSR FSM (IDLE->WRITE->BRESP->DONE->IDLE):
  - Leaves IDLE when the head kind is CSR.
  - wvalid in WRITE; bready in BRESP.
  - Timeout counter increments in WRITE/BRESP; reaching CSR_TIMEOUT forces DONE with error.
  - bvalid with bresp!=0 also sets error.
  - DONE with no error: commit as COMMIT (rd write).
  - DONE with error: exception with mcause 2, mtval 0, flush to mtvec.
  - The entry dequeues only in DONE.
- Interrupt:
  - irq_pend is set at the edge when irq_valid & (head EMPTY or commit_valid).
  - Next cycle: kind INTERRUPT, irq_taken=1, exc_valid=1, mcause={1,irq_num}, mepc=resume_pc, flush to mtvec, irq_pend cleared.
  - If commit_valid and irq coincide, the instruction retires first.
- resume_pc update on commit_valid: flush ? flush_pc : pc+4; otherwise hold. Arithmetic is modulo 2^XLEN.
- pending_rd: OR of one-hot(rd) over valid entries, bit 0 forced 0, combinational from queue state.

Decomposition:
- Package commit_pkg: commit_kind_e, csr_state_e, commit_entry_t struct, EXC_ILLEGAL_INST=2.
- Sub-module commit_entry_fifo (parametrised DEPTH, entry type, with flush clear) holds the queue.
- Classification, CSR FSM and interrupt logic live in commit_buffered.

Test Plan:
1. DEPTH=4, dfifo_full=1, enqueue 5 stores back-to-back -> ex_ready falls after the 4th; dfifo_full=0 -> 4 dfifo_valid pulses in order, ex_ready returns.
2. Enqueue ALU (rd=5,0x1234), taken branch (pc 0x100 -> 0x200), ALU -> 0x1234 written, flush with flush_pc=0x200, third entry discarded, pending_rd bit 5 clears.
3. CSR write, wready after 2 cycles, bvalid bresp=0 -> commit in DONE with rd written; repeat with bresp=2 -> exc_valid, mcause=2, flush_pc=mtvec.
4. CSR write with wready never asserted, CSR_TIMEOUT=16 -> exception exactly 17 cycles after WRITE entry, bready never asserted.
5. irq_valid, irq_num=7, with queue empty after commit of pc 0x40 -> next cycle irq_taken, mcause=0x80000007, mepc=0x44.
6. Assert reset during BRESP with 3 queued entries -> next cycle all outputs 0, queue empty, FSM IDLE.
